// File: rtl/mau_pkg.sv
// Shared types and helpers for the byte-serial load/store unit (mem_access_unit).
package mau_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DRAIN,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       sgn;
    } req_ctrl_t;

    // Number of memory bytes touched by a request; 0 flags the reserved encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    // Big-endian byte idx of the right-aligned nbytes-wide store value.
    function automatic logic [BYTE_W-1:0] store_byte(input logic [DATA_W-1:0] data,
                                                     input logic [2:0]        nbytes,
                                                     input logic [CNT_W-1:0]  idx);
        logic [1:0] from_lsb;
        from_lsb   = 2'(nbytes - 3'd1 - 3'(idx));
        store_byte = BYTE_W'(data >> {from_lsb, 3'b000});
    endfunction

endpackage

// File: rtl/mau_extend.sv
// Sign/zero extension of the assembled load accumulator to a 32-bit result.
module mau_extend
    import mau_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = acc;
        case (size)
            SZ_BYTE: result = {{24{sgn & acc[7]}}, acc[7:0]};
            SZ_HALF: result = {{16{sgn & acc[15]}}, acc[15:0]};
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator serialising word/half/byte requests onto a byte-wide memory.
// Optional MAU_BOUNDS_CHECK_EN rejects requests reaching beyond DM_DEPTH bytes.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata
);

`ifdef MAU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t            state, state_n;
    req_ctrl_t         ctrl, ctrl_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic              rd_pend;

    logic              resp_valid_n, resp_err_n, mem_read_n, mem_write_n;
    logic [DATA_W-1:0] resp_rdata_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [BYTE_W-1:0] mem_wdata_n;

    logic              accept, align_err, range_err, req_err, last;
    logic [2:0]        req_n, nbytes;
    logic [ADDR_W:0]   last_addr;
    logic [DATA_W-1:0] ext_data;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Acceptance-time checks on the incoming request.
    assign req_n     = size_bytes(req_size);
    assign align_err = (req_size == SZ_RSVD)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign last_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_n - 3'd1);
    assign range_err = BOUNDS_EN && (last_addr >= (ADDR_W+1)'(DM_DEPTH));
    assign req_err   = align_err || range_err;

    assign nbytes  = size_bytes(ctrl.size);
    assign cnt_inc = cnt + CNT_W'(1);
    assign last    = ((3'(cnt) + 3'd1) == nbytes);

    mau_extend u_extend (
        .size   (ctrl.size),
        .sgn    (ctrl.sgn),
        .acc    (acc_n),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ctrl       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            acc        <= '0;
            cnt        <= '0;
            rd_pend    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            ctrl       <= ctrl_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            rd_pend    <= mem_read;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            mem_read   <= mem_read_n;
            mem_write  <= mem_write_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_n      = state;
        ctrl_n       = ctrl;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        cnt_n        = cnt;
        acc_n        = rd_pend ? {acc[DATA_W-BYTE_W-1:0], mem_rdata} : acc;
        resp_valid_n = 1'b0;
        resp_rdata_n = '0;
        resp_err_n   = 1'b0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    ctrl_n  = '{write: req_write, size: req_size, sgn: req_signed};
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    cnt_n   = '0;
                    acc_n   = '0;
                    if (req_err) begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (req_write) begin
                        state_n     = ST_WRITE;
                        mem_write_n = 1'b1;
                        mem_addr_n  = req_addr;
                        mem_wdata_n = store_byte(req_wdata, req_n, '0);
                    end else begin
                        state_n    = ST_READ;
                        mem_read_n = 1'b1;
                        mem_addr_n = req_addr;
                    end
                end
            end
            ST_WRITE: begin
                if (last) begin
                    state_n      = ST_RESP;
                    resp_valid_n = 1'b1;
                end else begin
                    cnt_n       = cnt_inc;
                    mem_write_n = 1'b1;
                    mem_addr_n  = addr_q + ADDR_W'(cnt_inc);
                    mem_wdata_n = store_byte(wdata_q, nbytes, cnt_inc);
                end
            end
            ST_READ: begin
                if (last) begin
                    state_n = ST_DRAIN;
                end else begin
                    cnt_n      = cnt_inc;
                    mem_read_n = 1'b1;
                    mem_addr_n = addr_q + ADDR_W'(cnt_inc);
                end
            end
            // Last read byte lands in acc_n this cycle, so the result is taken from it.
            ST_DRAIN: begin
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = ext_data;
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

    localparam int unsigned DM = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h0;

    logic [7:0]  dev_mem [DM];
    logic [7:0]  ref_mem [DM];

    int total  = 0;
    int passed = 0;

    mem_access_unit #(.ADDR_W(32), .DM_DEPTH(DM)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-wide memory device: read data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_write) dev_mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= dev_mem[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit junk,
                          output logic [31:0] rd);
        int          n;
        int          lat;
        int          guard;
        int          overlap;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        got_err;
        logic [31:0] q_addr[$];
        bit          q_wr[$];
        logic [7:0]  q_data[$];

        n       = (sz == 2'b11) ? 0 : (1 << sz);
        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef MAU_BOUNDS_CHECK_EN
        if (!exp_err && (longint'(a) + longint'(n) - 1 >= longint'(DM))) exp_err = 1'b1;
`endif
        exp_rd = 32'h0;
        if (!w && !exp_err) begin
            for (int k = 0; k < n; k++) exp_rd = (exp_rd << 8) | 32'(ref_mem[10'(a + 32'(k))]);
            if (sg && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'h1 << (8*n)) - 32'h1);
        end

        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", 32'(req_ready), 32'h1);

        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        if (junk) begin
            req_write  = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end else begin
            req_valid = 1'b0;
        end

        lat     = 0;
        overlap = 0;
        got_err = 1'b0;
        rd      = 32'hx;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) overlap++;
            if (mem_read || mem_write) begin
                q_addr.push_back(mem_addr);
                q_wr.push_back(mem_write);
                q_data.push_back(mem_wdata);
            end
            if (resp_valid) begin
                lat     = c;
                got_err = resp_err;
                rd      = resp_rdata;
                req_valid = 1'b0;
                break;
            end
        end

        chk("resp_latency", 32'(lat), exp_err ? 32'd1 : (w ? 32'(n + 1) : 32'(n + 2)));
        chk("resp_err", 32'(got_err), 32'(exp_err));
        chk("resp_rdata", rd, exp_rd);
        chk("strobe_overlap", 32'(overlap), 32'h0);
        chk("strobe_count", 32'(q_addr.size()), exp_err ? 32'h0 : 32'(n));
        if (q_addr.size() == (exp_err ? 0 : n)) begin
            for (int k = 0; k < q_addr.size(); k++) begin
                chk("strobe_addr", q_addr[k], a + 32'(k));
                chk("strobe_kind", 32'(q_wr[k]), 32'(w));
                if (w) chk("strobe_wdata", 32'(q_data[k]), (wd >> (8 * (n - 1 - k))) & 32'hFF);
            end
        end

        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'h0);
        chk("ready_after_resp", 32'(req_ready), 32'h1);

        if (w && !exp_err)
            for (int k = 0; k < n; k++) ref_mem[10'(a + 32'(k))] = 8'((wd >> (8 * (n - 1 - k))) & 32'hFF);
    endtask

    initial begin
        logic [31:0] rd;
        int          seen;

        for (int i = 0; i < DM; i++) begin
            ref_mem[i] = 8'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[16'h10] = 8'h80; dev_mem[16'h10] = 8'h80;
        ref_mem[16'h11] = 8'h12; dev_mem[16'h11] = 8'h12;
        ref_mem[16'h12] = 8'h34; dev_mem[16'h12] = 8'h34;
        ref_mem[16'h13] = 8'h56; dev_mem[16'h13] = 8'h56;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'h1);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd);
        chk("tp_word_load", rd, 32'h80123456);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, rd);
        chk("tp_sbyte_load", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, rd);
        chk("tp_ubyte_load", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, rd);
        chk("tp_shalf_load", rd, 32'h00003456);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, rd);
        chk("tp_store_rdata", rd, 32'h0);
        do_req(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 1'b1, rd);
        chk("tp_readback", rd, 32'hDEADBEEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, rd);
        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, 1'b0, rd);
        do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 1'b0, rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, 1'b0, rd);
        do_req(1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000A55A, 1'b0, rd);

        // Reset during the second READ cycle of a word load.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_reading", 32'(mem_read), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("mid_rst_resp", 32'(resp_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid || mem_read || mem_write) seen++;
        end
        chk("post_rst_quiet", 32'(seen), 32'h0);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, rd);
        chk("post_rst_load", rd, 32'h00003456);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom), rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
